// File: rtl/lcd_time_writer.sv
// rtl/lcd_time_writer.sv - HD44780 8-bit write-only driver rendering HH:MM:SS[ AM|PM] on line 1
//
// Runs the LCD power-up wait and init command sequence after reset, then
// accepts BCD time snapshots over a valid/ready handshake and writes them
// to DDRAM address 0.
// Ports:
//   clk, reset           clock, asynchronous active-high reset
//   upd_valid/upd_ready  snapshot handshake (ready only while idle)
//   upd_h10..upd_s1      six BCD digits of the snapshot
//   upd_mode12, upd_pm   12h suffix enable and AM/PM select
//   lcd_rs/rw/e/db       HD44780 bus (rw tied low)
//   init_done            level, high once init sequence has completed
//   frame_done           one-cycle pulse when a frame's last byte wait ends
module lcd_time_writer #(
    parameter int T_POWERUP = 360000,
    parameter int E_HIGH    = 12,
    parameter int T_CMD     = 1000,
    parameter int T_CLEAR   = 40000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       upd_valid,
    output logic       upd_ready,
    input  logic [3:0] upd_h10,
    input  logic [3:0] upd_h1,
    input  logic [3:0] upd_m10,
    input  logic [3:0] upd_m1,
    input  logic [3:0] upd_s10,
    input  logic [3:0] upd_s1,
    input  logic       upd_mode12,
    input  logic       upd_pm,
    output logic       lcd_rs,
    output logic       lcd_rw,
    output logic       lcd_e,
    output logic [7:0] lcd_db,
    output logic       init_done,
    output logic       frame_done
);

    localparam int LEN_CMD = 1 + E_HIGH + T_CMD;
    localparam int LEN_CLR = 1 + E_HIGH + T_CLEAR;
    localparam int MAX_A   = (LEN_CMD > LEN_CLR) ? LEN_CMD : LEN_CLR;
    localparam int CNT_MAX = (T_POWERUP > MAX_A) ? T_POWERUP : MAX_A;
    localparam int CW      = $clog2(CNT_MAX + 1);

    localparam logic [CW-1:0] PWR_LAST = CW'(T_POWERUP - 1);
    localparam logic [CW-1:0] CMD_LAST = CW'(LEN_CMD - 1);
    localparam logic [CW-1:0] CLR_LAST = CW'(LEN_CLR - 1);
    localparam logic [CW-1:0] E_LAST   = CW'(E_HIGH);

    localparam logic [1:0] S_PWR   = 2'd0;
    localparam logic [1:0] S_INIT  = 2'd1;
    localparam logic [1:0] S_IDLE  = 2'd2;
    localparam logic [1:0] S_FRAME = 2'd3;

    logic [1:0]    state_q, state_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic [3:0]    idx_q, idx_d;
    logic [23:0]   dig_q, dig_d;
    logic          mode12_q, mode12_d;
    logic          pm_q, pm_d;
    logic          rs_q, rs_d;
    logic [7:0]    db_q, db_d;
    logic          init_done_q, init_done_d;
    logic          frame_done_q, frame_done_d;

    logic          busy;
    logic          is_clear;
    logic          byte_last;
    logic          load;

    function automatic logic [7:0] digit_char(input logic [3:0] d);
        return (d <= 4'd9) ? (8'h30 + {4'h0, d}) : 8'h3F;
    endfunction

    function automatic logic [7:0] init_byte(input logic [3:0] i);
        case (i)
            4'd0:    return 8'h38;
            4'd1:    return 8'h0C;
            4'd2:    return 8'h06;
            default: return 8'h01;
        endcase
    endfunction

    // Returns {rs, db}; index 0 is the DDRAM address command, the rest are characters.
    function automatic logic [8:0] frame_byte(input logic [3:0] i, input logic [23:0] dg,
                                              input logic pm);
        case (i)
            4'd0:    return {1'b0, 8'h80};
            4'd1:    return {1'b1, digit_char(dg[23:20])};
            4'd2:    return {1'b1, digit_char(dg[19:16])};
            4'd3:    return {1'b1, 8'h3A};
            4'd4:    return {1'b1, digit_char(dg[15:12])};
            4'd5:    return {1'b1, digit_char(dg[11:8])};
            4'd6:    return {1'b1, 8'h3A};
            4'd7:    return {1'b1, digit_char(dg[7:4])};
            4'd8:    return {1'b1, digit_char(dg[3:0])};
            4'd9:    return {1'b1, 8'h20};
            4'd10:   return {1'b1, pm ? 8'h50 : 8'h41};
            default: return {1'b1, 8'h4D};
        endcase
    endfunction

    assign busy      = (state_q == S_INIT) || (state_q == S_FRAME);
    assign is_clear  = (state_q == S_INIT) && (idx_q == 4'd3);
    assign byte_last = (cnt_q == (is_clear ? CLR_LAST : CMD_LAST));

    always_comb begin
        state_d      = state_q;
        cnt_d        = cnt_q;
        idx_d        = idx_q;
        dig_d        = dig_q;
        mode12_d     = mode12_q;
        pm_d         = pm_q;
        rs_d         = rs_q;
        db_d         = db_q;
        init_done_d  = init_done_q;
        frame_done_d = 1'b0;
        load         = 1'b0;

        case (state_q)
            S_PWR: begin
                if (cnt_q == PWR_LAST) begin
                    state_d = S_INIT;
                    cnt_d   = '0;
                    idx_d   = 4'd0;
                    load    = 1'b1;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_INIT: begin
                if (byte_last) begin
                    cnt_d = '0;
                    if (idx_q == 4'd3) begin
                        state_d     = S_IDLE;
                        init_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        load  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            S_IDLE: begin
                if (upd_valid) begin
                    state_d  = S_FRAME;
                    cnt_d    = '0;
                    idx_d    = 4'd0;
                    dig_d    = {upd_h10, upd_h1, upd_m10, upd_m1, upd_s10, upd_s1};
                    mode12_d = upd_mode12;
                    pm_d     = upd_pm;
                    load     = 1'b1;
                end
            end
            default: begin
                if (byte_last) begin
                    cnt_d = '0;
                    if (idx_q == (mode12_q ? 4'd11 : 4'd8)) begin
                        state_d      = S_IDLE;
                        frame_done_d = 1'b1;
                    end else begin
                        idx_d = idx_q + 4'd1;
                        load  = 1'b1;
                    end
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
        endcase

        // rs/db are registered at the edge that starts a byte so they are already
        // valid during its setup cycle and stay put until the next byte starts.
        if (load) begin
            if (state_d == S_INIT) begin
                {rs_d, db_d} = {1'b0, init_byte(idx_d)};
            end else begin
                {rs_d, db_d} = frame_byte(idx_d, dig_d, pm_d);
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q      <= S_PWR;
            cnt_q        <= '0;
            idx_q        <= '0;
            dig_q        <= '0;
            mode12_q     <= 1'b0;
            pm_q         <= 1'b0;
            rs_q         <= 1'b0;
            db_q         <= 8'h00;
            init_done_q  <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            idx_q        <= idx_d;
            dig_q        <= dig_d;
            mode12_q     <= mode12_d;
            pm_q         <= pm_d;
            rs_q         <= rs_d;
            db_q         <= db_d;
            init_done_q  <= init_done_d;
            frame_done_q <= frame_done_d;
        end
    end

    // E is decoded from registered state so an asynchronous reset drops it at once.
    assign lcd_e      = busy && (cnt_q != '0) && (cnt_q <= E_LAST);
    assign upd_ready  = (state_q == S_IDLE);
    assign lcd_rs     = rs_q;
    assign lcd_rw     = 1'b0;
    assign lcd_db     = db_q;
    assign init_done  = init_done_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_lcd_time_writer.sv
// tb/tb_lcd_time_writer.sv - directed self-checking bench for lcd_time_writer
module tb_lcd_time_writer;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       upd_valid = 1'b0;
    logic       upd_ready;
    logic [3:0] upd_h10 = 4'd0, upd_h1 = 4'd0, upd_m10 = 4'd0;
    logic [3:0] upd_m1 = 4'd0, upd_s10 = 4'd0, upd_s1 = 4'd0;
    logic       upd_mode12 = 1'b0, upd_pm = 1'b0;
    logic       lcd_rs, lcd_rw, lcd_e;
    logic [7:0] lcd_db;
    logic       init_done, frame_done;

    int tests = 0;
    int fails = 0;

    lcd_time_writer #(
        .T_POWERUP(20), .E_HIGH(2), .T_CMD(3), .T_CLEAR(6)
    ) dut (
        .clk(clk), .reset(reset),
        .upd_valid(upd_valid), .upd_ready(upd_ready),
        .upd_h10(upd_h10), .upd_h1(upd_h1), .upd_m10(upd_m10),
        .upd_m1(upd_m1), .upd_s10(upd_s10), .upd_s1(upd_s1),
        .upd_mode12(upd_mode12), .upd_pm(upd_pm),
        .lcd_rs(lcd_rs), .lcd_rw(lcd_rw), .lcd_e(lcd_e), .lcd_db(lcd_db),
        .init_done(init_done), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    // Byte monitor: records {rs,db} per e pulse, pulse width and bus stability.
    logic [8:0] bytes_q[$];
    logic [8:0] hi_val;
    int         hi_cnt = 0;
    int         bad_width = 0;
    int         db_changed = 0;

    always @(negedge clk) begin
        if (lcd_e) begin
            if (hi_cnt == 0) hi_val = {lcd_rs, lcd_db};
            else if ({lcd_rs, lcd_db} !== hi_val) db_changed++;
            hi_cnt++;
        end else if (hi_cnt != 0) begin
            bytes_q.push_back(hi_val);
            if (hi_cnt != 2) bad_width++;
            hi_cnt = 0;
        end
    end

    logic [8:0] exp_init[12] = '{9'h038, 9'h00C, 9'h006, 9'h001, 0, 0, 0, 0, 0, 0, 0, 0};
    logic [8:0] exp_f2[12]   = '{9'h080, 9'h131, 9'h132, 9'h13A, 9'h133, 9'h134,
                                 9'h13A, 9'h135, 9'h136, 0, 0, 0};
    logic [8:0] exp_f3[12]   = '{9'h080, 9'h130, 9'h139, 9'h13A, 9'h130, 9'h135,
                                 9'h13A, 9'h130, 9'h137, 9'h120, 9'h150, 9'h14D};
    logic [8:0] exp_f4[12]   = '{9'h080, 9'h131, 9'h13F, 9'h13A, 9'h134, 9'h135,
                                 9'h13A, 9'h135, 9'h139, 0, 0, 0};
    logic [8:0] exp_fy[12]   = '{9'h080, 9'h132, 9'h133, 9'h13A, 9'h135, 9'h139,
                                 9'h13A, 9'h130, 9'h131, 0, 0, 0};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_bytes(input string tag, input logic [8:0] exp[12], input int n);
        logic [8:0] got;
        chk({tag, " count"}, bytes_q.size(), n);
        for (int i = 0; i < n; i++) begin
            got = (i < bytes_q.size()) ? bytes_q[i] : 9'h1FF;
            chk($sformatf("%s byte%0d", tag, i), {23'd0, got}, {23'd0, exp[i]});
        end
        chk({tag, " e width"}, bad_width, 0);
        chk({tag, " bus stable"}, db_changed, 0);
    endtask

    // Called right after reset is released at a negedge.
    task automatic wait_init(input string tag);
        int n = 0;
        while (!init_done && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk({tag, " init latency"}, n, 47);
        chk({tag, " ready at init"}, {31'd0, upd_ready}, 1);
        check_bytes({tag, " init"}, exp_init, 4);
    endtask

    task automatic clear_mon();
        bytes_q.delete();
        bad_width  = 0;
        db_changed = 0;
    endtask

    // Presents a snapshot once ready, leaving the bench at the negedge after the accept edge.
    task automatic send(input logic [23:0] d, input logic m12, input logic pm, input logic hold);
        int n = 0;
        while (!upd_ready && n < 300) begin
            @(negedge clk);
            n++;
        end
        {upd_h10, upd_h1, upd_m10, upd_m1, upd_s10, upd_s1} = d;
        upd_mode12 = m12;
        upd_pm     = pm;
        upd_valid  = 1'b1;
        @(posedge clk);
        @(negedge clk);
        if (!hold) upd_valid = 1'b0;
    endtask

    task automatic wait_frame(input string tag, input int exp_k);
        int k = 0;
        int ready_seen = 0;
        if (upd_ready) ready_seen++;
        while (!frame_done && k < 300) begin
            @(negedge clk);
            k++;
            if (upd_ready && !frame_done) ready_seen++;
        end
        chk({tag, " frame latency"}, k, exp_k);
        chk({tag, " ready in frame_done"}, {31'd0, upd_ready}, 1);
        chk({tag, " busy ready"}, ready_seen, 0);
    endtask

    initial begin
        // Reset state
        @(negedge clk);
        chk("rst upd_ready", {31'd0, upd_ready}, 0);
        chk("rst lcd_e", {31'd0, lcd_e}, 0);
        chk("rst lcd_rs", {31'd0, lcd_rs}, 0);
        chk("rst lcd_rw", {31'd0, lcd_rw}, 0);
        chk("rst lcd_db", {24'd0, lcd_db}, 0);
        chk("rst init_done", {31'd0, init_done}, 0);
        chk("rst frame_done", {31'd0, frame_done}, 0);
        clear_mon();

        // 1: power-up and init
        reset = 1'b0;
        wait_init("t1");
        clear_mon();

        // 2: 12:34:56 24h
        send(24'h123456, 1'b0, 1'b0, 1'b0);
        wait_frame("t2", 54);
        check_bytes("t2", exp_f2, 9);
        @(negedge clk);
        chk("t2 frame_done one cycle", {31'd0, frame_done}, 0);
        chk("t2 db holds", {23'd0, lcd_rs, lcd_db}, 9'h136);
        clear_mon();

        // 3: 09:05:07 PM
        send(24'h090507, 1'b1, 1'b1, 1'b0);
        wait_frame("t3", 72);
        check_bytes("t3", exp_f3, 12);
        clear_mon();

        // 4: invalid hours-units digit renders as '?'
        send(24'h1C4559, 1'b0, 1'b0, 1'b0);
        wait_frame("t4", 54);
        check_bytes("t4", exp_f4, 9);
        clear_mon();

        // 5: valid held across frame; inputs change mid-frame
        send(24'h123456, 1'b0, 1'b0, 1'b1);
        {upd_h10, upd_h1, upd_m10, upd_m1, upd_s10, upd_s1} = 24'h235901;
        wait_frame("t5a", 54);
        check_bytes("t5a", exp_f2, 9);
        clear_mon();
        @(negedge clk);
        chk("t5 accepted in frame_done", {31'd0, upd_ready}, 0);
        {upd_h10, upd_h1, upd_m10, upd_m1, upd_s10, upd_s1} = 24'h777777;
        upd_valid = 1'b0;
        wait_frame("t5b", 54);
        check_bytes("t5b", exp_fy, 9);
        clear_mon();

        // 6: reset during byte 5 while e is high
        send(24'h123456, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 200; i++) begin
            if (bytes_q.size() == 4 && lcd_e) break;
            @(negedge clk);
        end
        chk("t6 reached byte5 e", {31'd0, lcd_e}, 1);
        reset = 1'b1;
        #1;
        chk("t6 lcd_e async", {31'd0, lcd_e}, 0);
        chk("t6 lcd_rs async", {31'd0, lcd_rs}, 0);
        chk("t6 lcd_db async", {24'd0, lcd_db}, 0);
        chk("t6 upd_ready async", {31'd0, upd_ready}, 0);
        chk("t6 init_done async", {31'd0, init_done}, 0);
        @(negedge clk);
        @(negedge clk);
        #1;
        clear_mon();
        @(negedge clk);
        reset = 1'b0;
        wait_init("t6");

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
